// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: per-channel 2-FF synchronizer feeding a
// stability FSM that only commits a new level after it has been held long enough.
//
// state     | meaning
// STABLE_LO | debounced level is 0, waiting for a candidate rise
// CHK_HI    | candidate rise seen, counting confirmations (btn_db still 0)
// STABLE_HI | debounced level is 1, waiting for a candidate fall
// CHK_LO    | candidate fall seen, counting confirmations (btn_db still 1)
module button_debounce #(
    parameter int N_BTN      = 4,
    parameter int STABLE_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_busy
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b11,
        CHK_LO    = 2'b10
    } state_t;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    // Synchronizer runs every clock so sample_en never widens the metastability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          db_q, db_d;
        logic          busy_q, busy_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= db_d;
                busy_q  <= busy_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            db_d    = db_q;
            if (sample_en) begin
                case (state_q)
                    STABLE_LO: begin
                        if (sync2_q[g]) begin
                            state_d = CHK_HI;
                            cnt_d   = '0;
                        end
                    end
                    CHK_HI: begin
                        if (!sync2_q[g]) begin
                            state_d = STABLE_LO;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = STABLE_HI;
                            db_d    = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    STABLE_HI: begin
                        if (!sync2_q[g]) begin
                            state_d = CHK_LO;
                            cnt_d   = '0;
                        end
                    end
                    CHK_LO: begin
                        if (sync2_q[g]) begin
                            state_d = STABLE_HI;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = STABLE_LO;
                            db_d    = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        db_d    = 1'b0;
                    end
                endcase
            end
            busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
        end

        assign btn_db[g]   = db_q;
        assign btn_busy[g] = busy_q;
    end

endmodule
